// File: rtl/rob_pkg.sv
// Shared ROB geometry and commit FSM state encoding.
package rob_pkg;
    localparam int unsigned NBANK = 4;
    localparam int unsigned NROW  = 128;
    localparam int unsigned PTR_W = $clog2(NROW);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
endpackage

// File: rtl/rob_commit_sel.sv
// Picks the in-order retirable prefix of the head row and flags the first
// mispredicting or excepting bank that ends it.
module rob_commit_sel #(
    parameter int unsigned NB = 4,
    parameter int unsigned IW = 2
) (
    input  logic [NB-1:0] i_pending,
    input  logic [NB-1:0] i_rdy,
    input  logic [NB-1:0] i_exc,
    input  logic [NB-1:0] i_mispred,
    output logic [NB-1:0] o_mask,
    output logic          o_trig,
    output logic          o_trig_exc,
    output logic [IW-1:0] o_idx
);
    logic w_stop;

    always_comb begin
        o_mask     = '0;
        o_trig     = 1'b0;
        o_trig_exc = 1'b0;
        o_idx      = '0;
        w_stop     = 1'b0;
        for (int k = 0; k < NB; k++) begin
            // Non-pending banks are already done and never block the prefix.
            if (!w_stop && i_pending[k]) begin
                if (!i_rdy[k]) begin
                    w_stop = 1'b1;
                end else if (i_exc[k]) begin
                    w_stop     = 1'b1;
                    o_trig     = 1'b1;
                    o_trig_exc = 1'b1;
                    o_idx      = IW'(k);
                end else begin
                    o_mask[k] = 1'b1;
                    if (i_mispred[k]) begin
                        w_stop = 1'b1;
                        o_trig = 1'b1;
                        o_idx  = IW'(k);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/rob_commit.sv
// ROB commit stage: retires head-row banks in order, tracks occupancy and
// turns a mispredict/exception into a one-cycle flush plus redirect handshake.
module rob_commit #(
    parameter int unsigned NBANK = rob_pkg::NBANK,
    parameter int unsigned NROW  = rob_pkg::NROW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    output logic [$clog2(NROW)-1:0]  tail_row,
    output logic [$clog2(NROW)-1:0]  head_row,
    input  logic [NBANK-1:0]         ent_valid,
    input  logic [NBANK-1:0]         ent_rdy,
    input  logic [NBANK-1:0]         ent_exc,
    input  logic [8*NBANK-1:0]       ent_exc_type,
    input  logic [NBANK-1:0]         ent_mispred,
    input  logic [32*NBANK-1:0]      ent_pc,
    input  logic [32*NBANK-1:0]      ent_target,
    input  logic [NBANK-1:0]         ent_has_rd,
    input  logic [5*NBANK-1:0]       ent_rd,
    input  logic [7*NBANK-1:0]       ent_pd,
    input  logic [8*NBANK-1:0]       ent_oldpd,
    output logic [NBANK-1:0]         cm_mask,
    output logic [NBANK-1:0]         cm_has_rd,
    output logic [5*NBANK-1:0]       cm_rd,
    output logic [7*NBANK-1:0]       cm_pd,
    output logic [8*NBANK-1:0]       cm_oldpd,
    output logic                     flush,
    output logic                     redirect_valid,
    input  logic                     redirect_ready,
    output logic [31:0]              redirect_pc,
    output logic                     redirect_exc,
    output logic [7:0]               redirect_exc_type
);
    import rob_pkg::*;

    localparam int unsigned PW = $clog2(NROW);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam logic [NBANK-1:0] ALL_DONE = '1;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_head, r_tail;
    logic [CW-1:0]      r_count;
    logic [NBANK-1:0]   r_done;
    logic [NBANK-1:0]   r_cm_mask, r_cm_has_rd;
    logic [5*NBANK-1:0] r_cm_rd;
    logic [7*NBANK-1:0] r_cm_pd;
    logic [8*NBANK-1:0] r_cm_oldpd;
    logic [31:0]        r_redir_pc;
    logic               r_redir_exc;
    logic [7:0]         r_redir_type;

    logic               w_run, w_active, w_alloc, w_row_done, w_trig, w_trig_exc;
    logic [NBANK-1:0]   w_pending, w_mask;
    logic [IW-1:0]      w_idx;
    logic [31:0]        w_pc_sel, w_tgt_sel;
    logic [7:0]         w_type_sel;

    assign w_run       = (r_state == ST_RUN);
    assign w_active    = w_run && (r_count != '0);
    assign w_pending   = w_active ? (ent_valid & ~r_done) : '0;
    assign alloc_ready = w_run && (r_count < CW'(NROW));
    assign w_alloc     = alloc_valid && alloc_ready;
    // Invalid banks count as done, so an all-invalid row completes at once.
    assign w_row_done  = w_active && !w_trig && ((r_done | w_mask | ~ent_valid) == ALL_DONE);

    assign w_pc_sel   = ent_pc[32*w_idx +: 32];
    assign w_tgt_sel  = ent_target[32*w_idx +: 32];
    assign w_type_sel = ent_exc_type[8*w_idx +: 8];

    rob_commit_sel #(
        .NB (NBANK),
        .IW (IW)
    ) u_sel (
        .i_pending  (w_pending),
        .i_rdy      (ent_rdy),
        .i_exc      (ent_exc),
        .i_mispred  (ent_mispred),
        .o_mask     (w_mask),
        .o_trig     (w_trig),
        .o_trig_exc (w_trig_exc),
        .o_idx      (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_done       <= '0;
            r_cm_mask    <= '0;
            r_cm_has_rd  <= '0;
            r_cm_rd      <= '0;
            r_cm_pd      <= '0;
            r_cm_oldpd   <= '0;
            r_redir_pc   <= '0;
            r_redir_exc  <= 1'b0;
            r_redir_type <= '0;
        end else begin
            r_cm_mask   <= w_mask;
            r_cm_has_rd <= ent_has_rd & w_mask;
            r_cm_rd     <= ent_rd;
            r_cm_pd     <= ent_pd;
            r_cm_oldpd  <= ent_oldpd;
            unique case (r_state)
                ST_RUN: begin
                    if (w_trig) begin
                        // Squash everything younger; the row after the trigger restarts empty.
                        r_state      <= ST_FLUSH;
                        r_head       <= r_head + 1'b1;
                        r_tail       <= r_head + 1'b1;
                        r_count      <= '0;
                        r_done       <= '0;
                        r_redir_pc   <= w_trig_exc ? w_pc_sel : w_tgt_sel;
                        r_redir_exc  <= w_trig_exc;
                        r_redir_type <= w_trig_exc ? w_type_sel : 8'h00;
                    end else begin
                        if (w_alloc) begin
                            r_tail <= r_tail + 1'b1;
                        end
                        r_count <= r_count + CW'(w_alloc) - CW'(w_row_done);
                        if (w_row_done) begin
                            r_head <= r_head + 1'b1;
                            r_done <= '0;
                        end else begin
                            r_done <= r_done | w_mask;
                        end
                    end
                end
                ST_FLUSH: r_state <= ST_REDIRECT;
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign head_row          = r_head;
    assign tail_row          = r_tail;
    assign cm_mask           = r_cm_mask;
    assign cm_has_rd         = r_cm_has_rd;
    assign cm_rd             = r_cm_rd;
    assign cm_pd             = r_cm_pd;
    assign cm_oldpd          = r_cm_oldpd;
    assign flush             = (r_state == ST_FLUSH);
    assign redirect_valid    = (r_state == ST_REDIRECT);
    assign redirect_pc       = r_redir_pc;
    assign redirect_exc      = r_redir_exc;
    assign redirect_exc_type = r_redir_type;
endmodule

// File: tb/tb_rob_commit.sv
// Randomized and directed bench for rob_commit against a row/bank-level
// occupancy model of the reorder buffer.
module tb_rob_commit;
    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_valid, alloc_ready;
    logic [6:0]   tail_row, head_row;
    logic [3:0]   ent_valid, ent_rdy, ent_exc, ent_mispred, ent_has_rd;
    logic [31:0]  ent_exc_type;
    logic [127:0] ent_pc, ent_target;
    logic [19:0]  ent_rd;
    logic [27:0]  ent_pd;
    logic [31:0]  ent_oldpd;
    logic [3:0]   cm_mask, cm_has_rd;
    logic [19:0]  cm_rd;
    logic [27:0]  cm_pd;
    logic [31:0]  cm_oldpd;
    logic         flush, redirect_valid, redirect_ready, redirect_exc;
    logic [31:0]  redirect_pc;
    logic [7:0]   redirect_exc_type;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .tail_row          (tail_row),
        .head_row          (head_row),
        .ent_valid         (ent_valid),
        .ent_rdy           (ent_rdy),
        .ent_exc           (ent_exc),
        .ent_exc_type      (ent_exc_type),
        .ent_mispred       (ent_mispred),
        .ent_pc            (ent_pc),
        .ent_target        (ent_target),
        .ent_has_rd        (ent_has_rd),
        .ent_rd            (ent_rd),
        .ent_pd            (ent_pd),
        .ent_oldpd         (ent_oldpd),
        .cm_mask           (cm_mask),
        .cm_has_rd         (cm_has_rd),
        .cm_rd             (cm_rd),
        .cm_pd             (cm_pd),
        .cm_oldpd          (cm_oldpd),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_ready    (redirect_ready),
        .redirect_pc       (redirect_pc),
        .redirect_exc      (redirect_exc),
        .redirect_exc_type (redirect_exc_type)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=run 1=flush 2=redirect.
    int         m_mode, m_head, m_tail, m_count;
    bit [3:0]   m_done, m_cm_mask, m_cm_has_rd;
    bit [19:0]  m_cm_rd;
    bit [27:0]  m_cm_pd;
    bit [31:0]  m_cm_oldpd, m_rpc;
    bit         m_rexc;
    bit [7:0]   m_rtype;

    task automatic model_reset();
        m_mode = 0; m_head = 0; m_tail = 0; m_count = 0; m_done = '0;
        m_cm_mask = '0; m_cm_has_rd = '0; m_cm_rd = '0; m_cm_pd = '0; m_cm_oldpd = '0;
        m_rpc = '0; m_rexc = 1'b0; m_rtype = '0;
    endtask

    task automatic check_outputs();
        chk_eq("alloc_ready", 32'(alloc_ready), 32'(m_mode == 0 && m_count < 128));
        chk_eq("head_row", 32'(head_row), 32'(m_head));
        chk_eq("tail_row", 32'(tail_row), 32'(m_tail));
        chk_eq("cm_mask", 32'(cm_mask), 32'(m_cm_mask));
        chk_eq("cm_has_rd", 32'(cm_has_rd), 32'(m_cm_has_rd));
        chk_eq("cm_rd", 32'(cm_rd), 32'(m_cm_rd));
        chk_eq("cm_pd", 32'(cm_pd), 32'(m_cm_pd));
        chk_eq("cm_oldpd", cm_oldpd, m_cm_oldpd);
        chk_eq("flush", 32'(flush), 32'(m_mode == 1));
        chk_eq("redirect_valid", 32'(redirect_valid), 32'(m_mode == 2));
        if (m_mode == 2) begin
            chk_eq("redirect_pc", redirect_pc, m_rpc);
            chk_eq("redirect_exc", 32'(redirect_exc), 32'(m_rexc));
            if (m_rexc) chk_eq("redirect_exc_type", 32'(redirect_exc_type), 32'(m_rtype));
        end
    endtask

    task automatic model_step();
        bit [3:0] mask = '0;
        bit       trig = 1'b0, texc = 1'b0, acc, complete;
        int       tk = 0;
        int       pend[$];
        if (m_mode == 0 && m_count > 0) begin
            for (int k = 0; k < 4; k++) if (ent_valid[k] && !m_done[k]) pend.push_back(k);
            foreach (pend[i]) begin
                int k = pend[i];
                if (!ent_rdy[k]) break;
                if (ent_exc[k]) begin trig = 1'b1; texc = 1'b1; tk = k; break; end
                mask[k] = 1'b1;
                if (ent_mispred[k]) begin trig = 1'b1; tk = k; break; end
            end
        end
        m_cm_mask = mask;
        m_cm_has_rd = ent_has_rd & mask;
        m_cm_rd = ent_rd; m_cm_pd = ent_pd; m_cm_oldpd = ent_oldpd;
        if (m_mode == 0) begin
            if (trig) begin
                m_mode = 1; m_head = (m_head + 1) % 128; m_tail = m_head;
                m_count = 0; m_done = '0;
                m_rexc = texc;
                m_rpc = texc ? ent_pc[32*tk +: 32] : ent_target[32*tk +: 32];
                m_rtype = texc ? ent_exc_type[8*tk +: 8] : 8'h00;
            end else begin
                acc = alloc_valid && (m_count < 128);
                complete = (m_count > 0) && ((m_done | mask | ~ent_valid) == 4'hf);
                if (acc) begin m_tail = (m_tail + 1) % 128; m_count++; end
                if (complete) begin m_head = (m_head + 1) % 128; m_count--; m_done = '0; end
                else m_done |= mask;
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
        end else if (redirect_ready) begin
            m_mode = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; ent_valid = 4'hf; ent_rdy = '0; ent_exc = '0; ent_mispred = '0;
        ent_exc_type = '0; ent_pc = '0; ent_target = '0; ent_has_rd = '0;
        ent_rd = '0; ent_pd = '0; ent_oldpd = '0; redirect_ready = 1'b0;
    endtask

    task automatic rand_inputs();
        alloc_valid = ($urandom_range(0, 3) != 0);
        ent_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
        ent_rdy = 4'($urandom);
        ent_exc = '0; ent_mispred = '0;
        if ($urandom_range(0, 15) == 0) ent_exc[$urandom_range(0, 3)] = 1'b1;
        if ($urandom_range(0, 9) == 0) ent_mispred[$urandom_range(0, 3)] = 1'b1;
        ent_exc_type = $urandom;
        ent_pc = {$urandom, $urandom, $urandom, $urandom};
        ent_target = {$urandom, $urandom, $urandom, $urandom};
        ent_has_rd = 4'($urandom); ent_rd = 20'($urandom);
        ent_pd = 28'($urandom); ent_oldpd = $urandom;
        redirect_ready = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk_eq("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk_eq("rst_head", 32'(head_row), 32'd0);

        // Two rows allocated, then row 0 fully ready.
        alloc_valid = 1'b1; cycle(); cycle(); alloc_valid = 1'b0;
        ent_rdy = 4'hf; ent_has_rd = 4'b0101; cycle();
        chk_eq("full_row_mask", 32'(cm_mask), 32'h0000000f);
        chk_eq("full_row_head", 32'(head_row), 32'd1);

        // Partial retire then the remainder.
        ent_rdy = 4'b1011; cycle();
        chk_eq("partial_mask", 32'(cm_mask), 32'h00000003);
        ent_rdy = 4'b1111; cycle();
        chk_eq("rest_mask", 32'(cm_mask), 32'h0000000c);
        chk_eq("rest_head", 32'(head_row), 32'd2);
        ent_rdy = 4'hf; cycle();
        chk_eq("empty_mask", 32'(cm_mask), 32'h00000000);

        // Mispredict in bank 1.
        ent_rdy = '0; alloc_valid = 1'b1; cycle(); alloc_valid = 1'b0;
        ent_rdy = 4'hf; ent_mispred = 4'b0010; ent_target[63:32] = 32'h80000100; cycle();
        ent_mispred = '0;
        chk_eq("mp_mask", 32'(cm_mask), 32'h00000003);
        chk_eq("mp_flush", 32'(flush), 32'd1);
        chk_eq("mp_head", 32'(head_row), 32'd3);
        cycle();
        chk_eq("mp_flush_one", 32'(flush), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_eq("mp_hold_pc", redirect_pc, 32'h80000100);
        end
        redirect_ready = 1'b1; cycle(); redirect_ready = 1'b0;
        chk_eq("mp_back_run", 32'(alloc_ready), 32'd1);

        // Exception in bank 2.
        ent_rdy = '0; alloc_valid = 1'b1; cycle(); alloc_valid = 1'b0;
        ent_rdy = 4'hf; ent_exc = 4'b0100; ent_exc_type[23:16] = 8'h02;
        ent_pc[95:64] = 32'h80000040; cycle();
        ent_exc = '0;
        chk_eq("exc_mask", 32'(cm_mask), 32'h00000003);
        cycle();
        chk_eq("exc_flag", 32'(redirect_exc), 32'd1);
        chk_eq("exc_pc", redirect_pc, 32'h80000040);
        chk_eq("exc_type", 32'(redirect_exc_type), 32'h02);
        redirect_ready = 1'b1; cycle(); redirect_ready = 1'b0;

        // Fill all 128 rows, then retire and allocate together across the wrap.
        idle_inputs(); do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 128; i++) cycle();
        chk_eq("full_not_ready", 32'(alloc_ready), 32'd0);
        ent_rdy = 4'hf;
        for (int i = 0; i < 128; i++) cycle();
        chk_eq("wrap_head", 32'(head_row), 32'd0);
        chk_eq("wrap_ready", 32'(alloc_ready), 32'd1);

        // Reset while a redirect is pending.
        idle_inputs(); do_reset();
        alloc_valid = 1'b1; cycle(); alloc_valid = 1'b0;
        ent_rdy = 4'hf; ent_mispred = 4'b0001; ent_target[31:0] = 32'h1234; cycle();
        ent_mispred = '0; cycle();
        chk_eq("pre_rst_redirect", 32'(redirect_valid), 32'd1);
        #2 rst = 1'b1; #1;
        chk_eq("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk_eq("rst_redirect_pc", redirect_pc, 32'd0);
        chk_eq("rst_flush", 32'(flush), 32'd0);
        chk_eq("rst_head_async", 32'(head_row), 32'd0);
        chk_eq("rst_cm_mask", 32'(cm_mask), 32'd0);
        do_reset();
        chk_eq("rst_release_ready", 32'(alloc_ready), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
